// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port, 1-cycle-read-latency memory between an
//            instruction-fetch requester (read-only) and a data requester
//            (read/write). Grants are combinational in the request cycle.
//            Returned read data is tagged back to whichever requester issued
//            the read. Data has priority by default.
// Config   : MEM_ARB_STARVE_GUARD_EN - when defined, a 4-bit streak counter
//            forces a fetch grant after STREAK_MAX consecutive data wins while
//            fetch is waiting. When undefined, data has strict priority.
// Ports    : clk, rst_n (async, active-low), clk_enable (global advance)
//            i_f_req/i_f_addr -> o_f_gnt, o_f_rvalid, o_f_rdata
//            i_d_req/i_d_we/i_d_addr/i_d_wdata -> o_d_gnt, o_d_rvalid, o_d_rdata
//            o_mem_addr/o_mem_re/o_mem_we/o_mem_wdata, i_mem_rdata
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_enable,
  // fetch requester
  input  logic              i_f_req,
  input  logic [ADDR_W-1:0] i_f_addr,
  output logic              o_f_gnt,
  output logic              o_f_rvalid,
  output logic [DATA_W-1:0] o_f_rdata,
  // data requester
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  // memory side
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  // Reject an out-of-range streak limit at elaboration; the counter is 4 bits.
  if (STREAK_MAX < 1 || STREAK_MAX > 15) begin : g_streak_max_range
    $error("mem_port_arbiter: STREAK_MAX must be in 1..15");
  end

  logic w_force_fetch;
  logic w_f_gnt;
  logic w_d_gnt;
  logic w_d_read;

  // Read-return owner flops: each one doubles as that requester's rvalid.
  logic f_rvalid_q, f_rvalid_d;
  logic d_rvalid_q, d_rvalid_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] c_streak_max = 4'(STREAK_MAX);

  logic [3:0] streak_q, streak_d;

  assign w_force_fetch = (streak_q == c_streak_max);

  always_comb begin
    streak_d = streak_q;
    if (clk_enable) begin
      if (w_f_gnt || !i_f_req) begin
        streak_d = 4'd0;
      end else if (w_d_gnt && (streak_q != 4'hF)) begin
        // Fetch is waiting and lost to data; saturate rather than wrap.
        streak_d = streak_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= 4'd0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign w_force_fetch = 1'b0;
`endif

  // Grant decision: at most one winner, nothing while frozen.
  always_comb begin
    w_f_gnt = clk_enable && i_f_req && (!i_d_req || w_force_fetch);
    w_d_gnt = clk_enable && i_d_req && !w_f_gnt;
    w_d_read = w_d_gnt && !i_d_we;
  end

  assign o_f_gnt = w_f_gnt;
  assign o_d_gnt = w_d_gnt;

  // Memory mux
  always_comb begin
    o_mem_addr = '0;
    if (w_f_gnt) begin
      o_mem_addr = i_f_addr;
    end else if (w_d_gnt) begin
      o_mem_addr = i_d_addr;
    end
  end

  assign o_mem_re    = w_f_gnt || w_d_read;
  assign o_mem_we    = w_d_gnt && i_d_we;
  assign o_mem_wdata = i_d_wdata;

  // Owner tagging: the memory answers one cycle after an enabled read, and it
  // is gated by the same enable, so frozen cycles simply hold the tag.
  always_comb begin
    f_rvalid_d = f_rvalid_q;
    d_rvalid_d = d_rvalid_q;
    if (clk_enable) begin
      f_rvalid_d = w_f_gnt;
      d_rvalid_d = w_d_read;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      f_rvalid_q <= f_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
    end
  end

  assign o_f_rvalid = f_rvalid_q;
  assign o_d_rvalid = d_rvalid_q;
  assign o_f_rdata  = i_mem_rdata;
  assign o_d_rdata  = i_mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. A behavioural model
//            (winner rule, pending-read tags, shadow memory) is compared to
//            the DUT every negative clock edge; directed sections add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int STREAK_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clk_enable = 1'b1;
  logic              f_req = 1'b0;
  logic [ADDR_W-1:0] f_addr = '0;
  logic              f_gnt, f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re, mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STREAK_MAX(STREAK_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt),
    .o_f_rvalid(f_rvalid), .o_f_rdata(f_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_addr(mem_addr), .o_mem_re(mem_re), .o_mem_we(mem_we),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory device driven by the DUT strobes, gated by the same enable.
  logic [DATA_W-1:0] dev_mem [256];
  always @(posedge clk) begin
    if (clk_enable) begin
      if (mem_we) dev_mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= dev_mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int                m_streak = 0;     // data wins in a row while fetch waited
  bit                m_pend_f = 1'b0;  // a fetch read is due back this cycle
  bit                m_pend_d = 1'b0;  // a data read is due back this cycle
  logic [DATA_W-1:0] m_rdata = '0;     // value that read must return
  logic [DATA_W-1:0] m_mem [256];

  // Who wins under the current inputs: 0 none, 1 fetch, 2 data.
  function automatic int winner(input bit en, input bit fr, input bit dr, input int streak);
    if (!en) return 0;
    if (fr && !dr) return 1;
    if (dr && !fr) return 2;
    if (fr && dr) return (GUARD && streak == STREAK_MAX) ? 1 : 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_streak <= 0;
      m_pend_f <= 1'b0;
      m_pend_d <= 1'b0;
    end else if (clk_enable) begin
      int w;
      w = winner(1'b1, f_req, d_req, m_streak);
      m_pend_f <= (w == 1);
      m_pend_d <= (w == 2) && !d_we;
      if (w == 1) m_rdata <= m_mem[f_addr];
      if (w == 2 && !d_we) m_rdata <= m_mem[d_addr];
      if (w == 2 && d_we) m_mem[d_addr] <= d_wdata;
      if (w == 1 || !f_req) m_streak <= 0;
      else if (m_streak < 15) m_streak <= m_streak + 1;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    int w;
    logic [ADDR_W-1:0] ea;
    w  = winner(clk_enable, f_req, d_req, m_streak);
    ea = (w == 1) ? f_addr : (w == 2) ? d_addr : '0;
    check("f_gnt",    32'(f_gnt),    32'(w == 1));
    check("d_gnt",    32'(d_gnt),    32'(w == 2));
    check("mem_addr", 32'(mem_addr), 32'(ea));
    check("mem_re",   32'(mem_re),   32'(w == 1 || (w == 2 && !d_we)));
    check("mem_we",   32'(mem_we),   32'(w == 2 && d_we));
    check("mem_wdata", mem_wdata, d_wdata);
    check("f_rvalid", 32'(f_rvalid), 32'(m_pend_f));
    check("d_rvalid", 32'(d_rvalid), 32'(m_pend_d));
    if (m_pend_f) check("f_rdata", f_rdata, m_rdata);
    if (m_pend_d) check("d_rdata", d_rdata, m_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; clk_enable = 1'b1;
  endtask

  int n_f, n_d, exp_f;

  initial begin
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      m_mem[i]   = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    end
    dev_mem[8'h10] = 32'hDEAD_BEEF;
    m_mem[8'h10]   = 32'hDEAD_BEEF;

    // Reset, no requests
    repeat (2) tick();
    check("rst_f_gnt", 32'(f_gnt), 0);
    check("rst_d_gnt", 32'(d_gnt), 0);
    check("rst_rvalid", 32'({f_rvalid, d_rvalid}), 0);
    check("rst_strobes", 32'({mem_re, mem_we}), 0);
    check("rst_addr", 32'(mem_addr), 0);
    rst_n = 1'b1;
    tick();

    // Fetch-only read of 0x10
    f_req = 1'b1; f_addr = 8'h10;
    #1;
    check("fo_gnt", 32'(f_gnt), 1);
    check("fo_addr", 32'(mem_addr), 32'h10);
    tick();
    f_req = 1'b0;
    #1;
    check("fo_rvalid", 32'(f_rvalid), 1);
    check("fo_rdata", f_rdata, 32'hDEAD_BEEF);
    check("fo_d_rvalid", 32'(d_rvalid), 0);
    tick();

    // Both request; data write wins, fetch follows
    f_req = 1'b1; f_addr = 8'h11;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 32'h5;
    #1;
    check("wr_d_gnt", 32'(d_gnt), 1);
    check("wr_we", 32'(mem_we), 1);
    check("wr_addr", 32'(mem_addr), 32'h20);
    tick();
    d_req = 1'b0; d_we = 1'b0;
    #1;
    check("wr_f_gnt", 32'(f_gnt), 1);
    check("wr_no_rvalid", 32'({f_rvalid, d_rvalid}), 0);
    tick();
    idle();
    tick();

    // Freeze with a data read outstanding and both requests pending
    f_req = 1'b1; f_addr = 8'h01;
    d_req = 1'b1; d_addr = 8'h20;
    #1;
    check("fz_first_gnt", 32'(d_gnt), 1);
    tick();
    clk_enable = 1'b0;
    #1;
    check("fz_rdata", d_rdata, 32'h5);
    for (int c = 0; c < 3; c++) begin
      check("fz_no_gnt", 32'({f_gnt, d_gnt}), 0);
      check("fz_no_strobe", 32'({mem_re, mem_we}), 0);
      check("fz_rvalid_held", 32'(d_rvalid), 1);
      tick();
    end
    clk_enable = 1'b1;
    #1;
    check("fz_resume", 32'({f_gnt, d_gnt}), 32'b01);
    tick();
    idle();
    tick();

    // Continuous contention for 10 cycles starting from a clear streak
    n_f = 0; n_d = 0;
    f_req = 1'b1; d_req = 1'b1; f_addr = 8'h02; d_addr = 8'h03;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_f += int'(f_gnt);
      n_d += int'(d_gnt);
      tick();
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_f = 2;
`else
    exp_f = 0;
`endif
    check("streak_f_count", 32'(n_f), 32'(exp_f));
    check("streak_d_count", 32'(n_d), 32'(10 - exp_f));
    idle();
    tick();

    // Alternating fetch/data reads each cycle
    for (int c = 0; c < 20; c++) begin
      f_req  = (c % 2 == 0);
      d_req  = (c % 2 == 1);
      f_addr = 8'(c);
      d_addr = 8'(c + 64);
      tick();
    end
    idle();
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      clk_enable = ($urandom_range(0, 9) != 0);
      f_req   = ($urandom_range(0, 9) < 6);
      d_req   = ($urandom_range(0, 9) < 6);
      d_we    = $urandom_range(0, 1) == 1;
      f_addr  = 8'($urandom_range(0, 15));
      d_addr  = 8'($urandom_range(0, 15));
      d_wdata = $urandom;
      tick();
    end
    idle();
    tick();

    // Reset pulse with a fetch read in flight
    f_req = 1'b1; f_addr = 8'h10;
    tick();
    f_req = 1'b0;
    #1;
    check("mr_rvalid_before", 32'(f_rvalid), 1);
    rst_n = 1'b0;
    #1;
    check("mr_rvalid_cleared", 32'(f_rvalid), 0);
    rst_n = 1'b1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
